// File: rtl/down_sampler_cfg_pkg.sv
// ---------------------------------------------------------------------------
// down_sampler_cfg_pkg
// Shared definitions for the configurable down-sampler slice:
//   - mode_e           : decimation mode encoding (pick / average)
//   - DEFAULT_LOG2_MAX : default largest legal ratio_log2 (ratio 1024)
//   - clamp_log2()     : limits a requested ratio_log2 to the legal maximum
// ---------------------------------------------------------------------------
package down_sampler_cfg_pkg;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    localparam int DEFAULT_LOG2_MAX = 10;

    function automatic int unsigned clamp_log2(input int unsigned req, input int unsigned lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/down_sampler_cfg_decim_phase_ctr.sv
// ---------------------------------------------------------------------------
// down_sampler_cfg_decim_phase_ctr
// Phase counter and shadow-configuration capture for the decimator.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   en, sync         : enable / phase restart (either one flushes the group)
//   data_in_vld      : input sample valid
//   mode, ratio_log2 : requested configuration (sampled at group start)
//   accept           : sample accepted this cycle
//   group_start      : accepted sample is the first of a group
//   group_end        : accepted sample closes the group
//   cfg_ratio_log2   : ratio_log2 in force for the current sample (clamped)
//   cfg_mode         : mode in force for the current sample
//   cfg_err          : sticky, a requested ratio_log2 was out of range
// ---------------------------------------------------------------------------
module down_sampler_cfg_decim_phase_ctr
    import down_sampler_cfg_pkg::*;
#(
    parameter int LOG2_MAX = DEFAULT_LOG2_MAX,
    parameter int LOG2_W   = 4
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              sync,
    input  logic              data_in_vld,
    input  logic              mode,
    input  logic [LOG2_W-1:0] ratio_log2,
    output logic              accept,
    output logic              group_start,
    output logic              group_end,
    output logic [LOG2_W-1:0] cfg_ratio_log2,
    output logic              cfg_mode,
    output logic              cfg_err
);

    localparam int PHASE_W = LOG2_MAX + 1;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] last_phase;
    logic [LOG2_W-1:0]  shadow_ratio;
    logic               shadow_mode;
    logic [LOG2_W-1:0]  req_ratio;
    logic               req_bad;
    logic               phase_zero;

    assign accept      = en && data_in_vld && !sync;
    assign phase_zero  = (phase == '0);
    assign group_start = accept && phase_zero;

    assign req_bad   = (ratio_log2 > LOG2_W'(LOG2_MAX));
    assign req_ratio = LOG2_W'(clamp_log2(32'(ratio_log2), LOG2_MAX));

    // The first sample of a group must already obey the new configuration
    // (with N = 1 it is also the closing sample), so at phase 0 the live
    // request is used directly; afterwards the captured shadow copy is used.
    assign cfg_ratio_log2 = phase_zero ? req_ratio : shadow_ratio;
    assign cfg_mode       = phase_zero ? mode      : shadow_mode;

    assign last_phase = (PHASE_W'(1) << cfg_ratio_log2) - PHASE_W'(1);
    assign group_end  = accept && (phase == last_phase);

    // Phase advances only on accepted samples; en low or sync restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= '0;
        end else if (!en || sync) begin
            phase <= '0;
        end else if (accept) begin
            phase <= group_end ? '0 : phase + PHASE_W'(1);
        end
    end

    // Shadow configuration is frozen for the remainder of the group.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_ratio <= '0;
            shadow_mode  <= MODE_PICK;
        end else if (group_start) begin
            shadow_ratio <= req_ratio;
            shadow_mode  <= mode;
        end
    end

    // Error flag is sticky until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_err <= 1'b0;
        end else if (group_start && req_bad) begin
            cfg_err <= 1'b1;
        end
    end

endmodule

// File: rtl/down_sampler_cfg.sv
// ---------------------------------------------------------------------------
// down_sampler_cfg
// Runtime-configurable decimator (ratio 2^ratio_log2) for the phase-noise
// sample path. Pick mode forwards the last sample of each group, average
// mode outputs the floor of the group mean. Valid-only handshake.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   en            : block enable, 0 flushes the partial group
//   sync          : restart the decimation phase, discard partial group
//   mode          : 0 = pick, 1 = average
//   ratio_log2    : decimation ratio exponent (clamped to LOG2_MAX)
//   data_in/_vld  : signed input sample and its valid
//   data_out/_vld : registered decimated sample and one-cycle strobe
//   cfg_err       : sticky, an out-of-range ratio_log2 was latched
// ---------------------------------------------------------------------------
module down_sampler_cfg
    import down_sampler_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_MAX   = DEFAULT_LOG2_MAX,
    parameter int LOG2_W     = 4
)
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  mode,
    input  logic [LOG2_W-1:0]     ratio_log2,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_vld,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_vld,
    output logic                  cfg_err
);

    // Wide enough to hold 2^LOG2_MAX full-scale samples without overflow.
    localparam int ACC_W = DATA_WIDTH + LOG2_MAX;

    logic                    accept;
    logic                    group_start;
    logic                    group_end;
    logic [LOG2_W-1:0]       cfg_ratio_log2;
    logic                    cfg_mode;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] sum;
    logic [DATA_WIDTH-1:0]   avg_value;
    logic [DATA_WIDTH-1:0]   out_value;

    down_sampler_cfg_decim_phase_ctr #(
        .LOG2_MAX (LOG2_MAX),
        .LOG2_W   (LOG2_W)
    ) u_phase_ctr (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .sync           (sync),
        .data_in_vld    (data_in_vld),
        .mode           (mode),
        .ratio_log2     (ratio_log2),
        .accept         (accept),
        .group_start    (group_start),
        .group_end      (group_end),
        .cfg_ratio_log2 (cfg_ratio_log2),
        .cfg_mode       (cfg_mode),
        .cfg_err        (cfg_err)
    );

    // The closing sample is folded in the same cycle, so the group sum is
    // formed combinationally. A new group never inherits a stale sum.
    assign data_ext  = {{LOG2_MAX{data_in[DATA_WIDTH-1]}}, data_in};
    assign acc_base  = group_start ? '0 : acc;
    assign sum       = acc_base + data_ext;
    // Arithmetic shift gives floor rounding toward -inf.
    assign avg_value = DATA_WIDTH'(sum >>> cfg_ratio_log2);
    assign out_value = (cfg_mode == MODE_AVG) ? avg_value : data_in;

    // Accumulate-and-dump; clears on flush and after each closing sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (!en || sync) begin
            acc <= '0;
        end else if (accept) begin
            acc <= group_end ? '0 : sum;
        end
    end

    // Output register: strobe for one cycle, data held between strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_vld <= 1'b0;
            data_out     <= '0;
        end else begin
            data_out_vld <= group_end;
            if (group_end) begin
                data_out <= out_value;
            end
        end
    end

endmodule

// File: tb/tb_down_sampler_cfg.sv
// ---------------------------------------------------------------------------
// tb_down_sampler_cfg
// Self-checking bench for down_sampler_cfg: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run compared against
// a group-level reference model.
// ---------------------------------------------------------------------------
module tb_down_sampler_cfg;

    localparam int DW   = 32;
    localparam int LMAX = 10;
    localparam int LW   = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          sync;
    logic          mode;
    logic [LW-1:0] ratio_log2;
    logic [DW-1:0] data_in;
    logic          data_in_vld;
    logic [DW-1:0] data_out;
    logic          data_out_vld;
    logic          cfg_err;

    int vectors     = 0;
    int miscompares = 0;

    down_sampler_cfg #(
        .DATA_WIDTH (DW),
        .LOG2_MAX   (LMAX),
        .LOG2_W     (LW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .sync         (sync),
        .mode         (mode),
        .ratio_log2   (ratio_log2),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    // Strobed outputs are collected on the falling edge for sequence checks.
    logic [DW-1:0] strobes[$];
    logic [DW-1:0] exp_strobes[$];

    always @(negedge clk) begin
        if (data_out_vld === 1'b1) strobes.push_back(data_out);
    end

    // Reference model: a group is a list of accepted samples; when it holds
    // N samples it produces either the last sample or the floored mean.
    longint        grp_q[$];
    int            m_log;
    logic          m_mode;
    logic          m_vld;
    logic [DW-1:0] m_out;
    logic          m_err;

    function automatic void model_reset();
        grp_q.delete();
        m_log  = 0;
        m_mode = 1'b0;
        m_vld  = 1'b0;
        m_out  = '0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(input logic e, input logic s, input logic m,
                                       input logic [LW-1:0] r, input logic v,
                                       input logic [DW-1:0] d);
        longint sum;
        longint n;
        longint q;
        m_vld = 1'b0;
        if (!e || s) begin
            grp_q.delete();
        end else if (v) begin
            if (grp_q.size() == 0) begin
                m_log  = (int'(r) > LMAX) ? LMAX : int'(r);
                m_mode = m;
                if (int'(r) > LMAX) m_err = 1'b1;
            end
            grp_q.push_back(longint'($signed(d)));
            n = longint'(1) << m_log;
            if (longint'(grp_q.size()) == n) begin
                if (!m_mode) begin
                    m_out = d;
                end else begin
                    sum = 0;
                    foreach (grp_q[k]) sum += grp_q[k];
                    q = sum / n;
                    if (sum < 0 && q * n != sum) q = q - 1;
                    m_out = q[DW-1:0];
                end
                m_vld = 1'b1;
                grp_q.delete();
            end
        end
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] got,
                                input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic apply_stimulus(input logic e, input logic s, input logic m,
                                  input logic [LW-1:0] r, input logic v,
                                  input logic [DW-1:0] d);
        en          = e;
        sync        = s;
        mode        = m;
        ratio_log2  = r;
        data_in_vld = v;
        data_in     = d;
        model_step(e, s, m, r, v, d);
        @(posedge clk);
        #1;
        check_output("model_vld", {31'd0, data_out_vld}, {31'd0, m_vld});
        check_output("model_out", data_out, m_out);
        check_output("model_err", {31'd0, cfg_err}, {31'd0, m_err});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0);
    endtask

    task automatic check_strobes(input string name);
        check_output({name, "_count"}, DW'(strobes.size()), DW'(exp_strobes.size()));
        foreach (exp_strobes[k]) begin
            if (k < strobes.size()) check_output(name, strobes[k], exp_strobes[k]);
            else check_output(name, 'x, exp_strobes[k]);
        end
        strobes.delete();
        exp_strobes.delete();
    endtask

    // Single-cycle vector table with hand-computed expected outputs.
    typedef struct {
        logic          e;
        logic          s;
        logic          m;
        logic [LW-1:0] r;
        logic          v;
        logic [DW-1:0] d;
        logic          xv;
        logic [DW-1:0] xo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input logic e, input logic s, input logic m,
                                    input logic [LW-1:0] r, input logic v,
                                    input logic [DW-1:0] d, input logic xv,
                                    input logic [DW-1:0] xo);
        vec_t t;
        t.e = e; t.s = s; t.m = m; t.r = r; t.v = v; t.d = d; t.xv = xv; t.xo = xo;
        tbl.push_back(t);
    endfunction

    initial begin
        rstn        = 1'b0;
        en          = 1'b0;
        sync        = 1'b0;
        mode        = 1'b0;
        ratio_log2  = '0;
        data_in     = '0;
        data_in_vld = 1'b0;
        model_reset();

        #12;
        check_output("reset_vld", {31'd0, data_out_vld}, 32'd0);
        check_output("reset_out", data_out, 32'd0);
        check_output("reset_err", {31'd0, cfg_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through, ratio 1
        for (int i = 0; i < 8; i++) add_vec(1, 0, 0, 4'd0, 1, DW'(i), 1, DW'(i));
        // Average of 1,2,3,4 and of -4,-4,-4,-3
        add_vec(1, 0, 1, 4'd2, 1, 32'd1, 0, 32'd7);
        add_vec(1, 0, 1, 4'd2, 1, 32'd2, 0, 32'd7);
        add_vec(1, 0, 1, 4'd2, 1, 32'd3, 0, 32'd7);
        add_vec(1, 0, 1, 4'd2, 1, 32'd4, 1, 32'd2);
        add_vec(1, 0, 1, 4'd2, 1, 32'hFFFF_FFFC, 0, 32'd2);
        add_vec(1, 0, 1, 4'd2, 1, 32'hFFFF_FFFC, 0, 32'd2);
        add_vec(1, 0, 1, 4'd2, 1, 32'hFFFF_FFFC, 0, 32'd2);
        add_vec(1, 0, 1, 4'd2, 1, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFC);
        // Sync after two samples, then 10..13
        add_vec(1, 0, 0, 4'd2, 1, 32'd20, 0, 32'hFFFF_FFFC);
        add_vec(1, 0, 0, 4'd2, 1, 32'd21, 0, 32'hFFFF_FFFC);
        add_vec(1, 1, 0, 4'd2, 1, 32'd99, 0, 32'hFFFF_FFFC);
        for (int i = 10; i < 13; i++) add_vec(1, 0, 0, 4'd2, 1, DW'(i), 0, 32'hFFFF_FFFC);
        add_vec(1, 0, 0, 4'd2, 1, 32'd13, 1, 32'd13);
        // Sync on the closing sample suppresses the strobe
        for (int i = 30; i < 33; i++) add_vec(1, 0, 0, 4'd2, 1, DW'(i), 0, 32'd13);
        add_vec(1, 1, 0, 4'd2, 1, 32'd33, 0, 32'd13);
        // en low mid-group flushes and holds data_out
        add_vec(1, 0, 0, 4'd2, 1, 32'd40, 0, 32'd13);
        add_vec(1, 0, 0, 4'd2, 1, 32'd41, 0, 32'd13);
        add_vec(0, 0, 0, 4'd2, 1, 32'd42, 0, 32'd13);
        add_vec(0, 0, 0, 4'd2, 0, 32'd43, 0, 32'd13);
        for (int i = 50; i < 53; i++) add_vec(1, 0, 0, 4'd2, 1, DW'(i), 0, 32'd13);
        add_vec(1, 0, 0, 4'd2, 1, 32'd53, 1, 32'd53);
        // Valid gaps do not advance the phase
        add_vec(1, 0, 0, 4'd2, 1, 32'd60, 0, 32'd53);
        add_vec(1, 0, 0, 4'd2, 0, 32'd77, 0, 32'd53);
        add_vec(1, 0, 0, 4'd2, 1, 32'd61, 0, 32'd53);
        add_vec(1, 0, 0, 4'd2, 0, 32'd78, 0, 32'd53);
        add_vec(1, 0, 0, 4'd2, 1, 32'd62, 0, 32'd53);
        add_vec(1, 0, 0, 4'd2, 1, 32'd63, 1, 32'd63);
        // Average with N = 1 forwards the sample
        add_vec(1, 0, 1, 4'd0, 1, 32'hFFFF_FFFB, 1, 32'hFFFF_FFFB);

        foreach (tbl[k]) begin
            apply_stimulus(tbl[k].e, tbl[k].s, tbl[k].m, tbl[k].r, tbl[k].v, tbl[k].d);
            check_output("tbl_vld", {31'd0, data_out_vld}, {31'd0, tbl[k].xv});
            check_output("tbl_out", data_out, tbl[k].xo);
        end
        idle(2);
        strobes.delete();

        // Pick, ratio 4: continuous ramp, then the same ramp with random gaps
        for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 0, 4'd2, 1, DW'(i));
        idle(2);
        exp_strobes = '{32'd3, 32'd7, 32'd11, 32'd15};
        check_strobes("pick_ramp");
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                apply_stimulus(1, 0, 0, 4'd2, 0, $urandom);
            apply_stimulus(1, 0, 0, 4'd2, 1, DW'(i));
        end
        idle(2);
        exp_strobes = '{32'd3, 32'd7, 32'd11, 32'd15};
        check_strobes("pick_gaps");

        // Ratio change mid-group applies from the next group
        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, (i < 2) ? 4'd2 : 4'd1, 1, DW'(i));
        idle(2);
        exp_strobes = '{32'd3, 32'd5, 32'd7, 32'd9};
        check_strobes("cfg_midgroup");

        // Full-scale average over the largest ratio
        for (int i = 0; i < 1024; i++) apply_stimulus(1, 0, 1, 4'd10, 1, 32'h7FFF_FFFF);
        idle(2);
        exp_strobes = '{32'h7FFF_FFFF};
        check_strobes("avg_fullscale");

        // Out-of-range ratio clamps to 1024 and sets cfg_err
        for (int i = 0; i < 1024; i++) apply_stimulus(1, 0, 0, 4'd15, 1, DW'(i));
        idle(2);
        check_output("clamp_err", {31'd0, cfg_err}, 32'd1);
        exp_strobes = '{32'd1023};
        check_strobes("clamp_ratio");

        // Asynchronous reset mid-group
        apply_stimulus(1, 0, 0, 4'd2, 1, 32'd100);
        apply_stimulus(1, 0, 0, 4'd2, 1, 32'd101);
        data_in_vld = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_output("rst_mid_vld", {31'd0, data_out_vld}, 32'd0);
        check_output("rst_mid_out", data_out, 32'd0);
        check_output("rst_mid_err", {31'd0, cfg_err}, 32'd0);
        #2 rstn = 1'b1;
        strobes.delete();
        for (int i = 60; i < 64; i++) apply_stimulus(1, 0, 0, 4'd2, 1, DW'(i));
        idle(2);
        exp_strobes = '{32'd63};
        check_strobes("rst_fresh_phase");

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [LW-1:0] r;
            r = ($urandom_range(0, 15) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 3));
            apply_stimulus($urandom_range(0, 15) != 0, $urandom_range(0, 31) == 0,
                           1'($urandom_range(0, 1)), r, $urandom_range(0, 3) != 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
